// File: rtl/xs3_digit_decoder.sv
// Receive side of the XS3 datapath: collects LSD-first Excess-3 digits,
// converts them to BCD and hands the packed word downstream.
module xs3_digit_decoder #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned CW      = $clog2(NDIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_xs3,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] out_bcd,
  output logic [CW-1:0]        out_count,
  output logic                 out_err
);

  localparam int unsigned IW = $clog2(NDIGITS);
  localparam int unsigned BW = 4 * NDIGITS;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [BW-1:0]   r_acc;
  logic            r_err;
  logic [BW-1:0]   r_out_bcd;
  logic [CW-1:0]   r_out_count;
  logic            r_out_err;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [BW-1:0]   w_acc_nxt;
  logic            w_err_nxt;
  logic [BW-1:0]   w_out_bcd_nxt;
  logic [CW-1:0]   w_out_count_nxt;
  logic            w_out_err_nxt;

  logic            w_legal;
  logic [3:0]      w_dig_bcd;
  logic [BW-1:0]   w_acc_wr;
  logic            w_final;

  // Per-digit conversion; illegal codes land as zero in their slot.
  always_comb begin
    w_legal   = (in_xs3 >= 4'd3) && (in_xs3 <= 4'd12);
    w_dig_bcd = w_legal ? (in_xs3 - 4'd3) : 4'd0;
    w_acc_wr  = r_acc;
    for (int k = 0; k < int'(NDIGITS); k++) begin
      if (IW'(k) == r_idx) w_acc_wr[4*k +: 4] = w_dig_bcd;
    end
    w_final = in_last || (r_idx == IW'(NDIGITS - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_acc_nxt       = r_acc;
    w_err_nxt       = r_err;
    w_out_bcd_nxt   = r_out_bcd;
    w_out_count_nxt = r_out_count;
    w_out_err_nxt   = r_out_err;
    case (r_state)
      COLLECT: begin
        if (in_valid) begin
          w_acc_nxt = w_acc_wr;
          w_err_nxt = r_err | ~w_legal;
          w_idx_nxt = r_idx + IW'(1);
          if (w_final) begin
            w_state_nxt     = HOLD;
            w_out_bcd_nxt   = w_acc_wr;
            w_out_count_nxt = CW'(r_idx) + CW'(1);
            w_out_err_nxt   = r_err | ~w_legal;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = COLLECT;
          w_idx_nxt   = '0;
          w_acc_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_out_bcd   <= '0;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_err       <= w_err_nxt;
      r_out_bcd   <= w_out_bcd_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_err   <= w_out_err_nxt;
    end
  end

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == HOLD);
  assign out_bcd   = r_out_bcd;
  assign out_count = r_out_count;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_xs3_digit_decoder.sv
// Scoreboard bench for xs3_digit_decoder: directed words, expected words
// queued at issue time and checked by an independent output monitor.
module tb_xs3_digit_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [4*ND-1:0] bcd;
    logic [CW-1:0]   cnt;
    logic            err;
  } word_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_xs3;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [4*ND-1:0] out_bcd;
  logic [CW-1:0]   out_count;
  logic            out_err;

  int checks = 0;
  int errors = 0;
  word_t exp_q[$];

  xs3_digit_decoder #(.NDIGITS(ND)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_xs3(in_xs3), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_count(out_count), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_word(input logic [4*ND-1:0] bcd, input int cnt, input logic err);
    word_t w;
    w.bcd = bcd;
    w.cnt = CW'(cnt);
    w.err = err;
    exp_q.push_back(w);
  endtask

  // Called at a negedge; returns at the negedge after the digit is accepted.
  task automatic send(input logic [3:0] xs3, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_xs3   = xs3;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a word is consumed on the edge following valid&ready with rst low.
  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      word_t w;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got bcd %h count %0d err %0b expected none",
                 out_bcd, out_count, out_err);
      end else begin
        w = exp_q.pop_front();
        chk("word_bcd", 32'(out_bcd), 32'(w.bcd));
        chk("word_count", 32'(out_count), 32'(w.cnt));
        chk("word_err", 32'(out_err), 32'(w.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_xs3 = 4'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);

    // Full word with latency checks
    expect_word(16'h0951, 4, 1'b0);
    send(4'h4, 1'b0); send(4'h8, 1'b0); send(4'hC, 1'b0); send(4'h3, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lat_in_ready_back", 32'(in_ready), 32'd1);
    chk("lat_out_valid_low", 32'(out_valid), 32'd0);
    idle(1);

    // Short word with an idle gap mid-word
    expect_word(16'h0024, 2, 1'b0);
    send(4'h7, 1'b0);
    idle(3);
    send(4'h5, 1'b1);
    idle(2);

    // Illegal code, then a clean word
    expect_word(16'h0300, 3, 1'b1);
    send(4'h3, 1'b0); send(4'hF, 1'b0); send(4'h6, 1'b1);
    expect_word(16'h0001, 1, 1'b0);
    send(4'h4, 1'b1);
    idle(2);

    // Backpressure with a held digit
    out_ready = 1'b0;
    expect_word(16'h0001, 1, 1'b0);
    send(4'h4, 1'b1);
    in_valid = 1'b1; in_xs3 = 4'h5; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_bcd", 32'(out_bcd), 32'h0001);
      @(negedge clk);
    end
    out_ready = 1'b1;
    expect_word(16'h0002, 2, 1'b0);
    send(4'h5, 1'b0); send(4'h3, 1'b1);
    idle(2);

    // Auto-terminate after ND digits
    expect_word(16'h9999, 4, 1'b0);
    expect_word(16'h0009, 2, 1'b0);
    for (int i = 0; i < 5; i++) send(4'hC, 1'b0);
    send(4'h3, 1'b1);
    idle(2);

    // Mid-word reset discards partial digits
    send(4'h8, 1'b0); send(4'h9, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    expect_word(16'h0000, 1, 1'b0);
    send(4'h3, 1'b1);
    idle(1);

    // Reset while a word is pending in HOLD
    out_ready = 1'b0;
    send(4'h9, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("hold_rst_out_valid", 32'(out_valid), 32'd0);
    chk("hold_rst_in_ready", 32'(in_ready), 32'd1);
    idle(3);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xs3_digit_decoder.md
Name: xs3_digit_decoder

Overview:
- Receive side of the XS3 arithmetic datapath.
- Accepts a serial stream of 4-bit Excess-3 result digits over a valid/ready handshake, least-significant digit first.
- Converts each digit back to BCD (subtract 3) and flags illegal XS3 codes.
- Assembles up to NDIGITS digits into one packed BCD word, presented downstream on a second valid/ready handshake.

Parameters:
- NDIGITS, 4, maximum digits per word; legal range 2..8.
- CW, $clog2(NDIGITS+1), width of the digit-count output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_xs3/in_last are valid.
- in_ready  output  1  block can accept a digit this cycle.
- in_xs3  input  4  XS3-coded digit; legal codes 4'd3..4'd12.
- in_last  input  1  marks the final digit of the current word.
- out_valid  output  1  assembled word available.
- out_ready  input  1  downstream accepts the word.
- out_bcd  output  4*NDIGITS  packed BCD; digit k occupies bits [4k+3:4k].
- out_count  output  CW  number of digits received for this word, 1..NDIGITS.
- out_err  output  1  at least one digit of this word was an illegal XS3 code.

Behaviour:
- States: COLLECT and HOLD. Reset state is COLLECT.
- Reset values: digit index 0, accumulator 0, out_bcd 0, out_count 0, out_err 0, out_valid 0. in_ready is 1 in the first cycle after reset.
- in_ready = (state == COLLECT). out_valid = (state == HOLD). Both are registered-state decodes with no combinational path from in_valid or out_ready.
- A digit is accepted when in_valid && in_ready.
- Conversion of an accepted digit:
  - Legal code (3..12): bcd = in_xs3 - 4'd3.
  - Illegal code (0..2 or 13..15): store 4'd0 in that slot and set the sticky word error flag.
- The converted digit is written to slot index, then index increments.
- Slots not yet written in the current word read as 0.
- COLLECT -> HOLD when an accepted digit has in_last == 1 or index == NDIGITS-1. The word is therefore auto-terminated after NDIGITS digits even without in_last.
- On that transition, out_bcd, out_count (= index+1) and out_err (sticky flag OR'd with the current digit's error) are registered.
- out_valid rises in the cycle after the final digit is accepted: latency is 1 clock from the final digit to out_valid.
- HOLD: out_bcd, out_count and out_err are stable while out_valid is high and out_ready is low.
- HOLD -> COLLECT when out_ready is high.
  - Same edge: index, accumulator and sticky error are cleared.
  - in_ready returns high the next cycle.
  - Minimum spacing between words is therefore one bubble cycle.
- Outputs after handoff: out_bcd, out_count and out_err keep their last values after the handoff; they are meaningful only while out_valid is high.
- in_valid while in HOLD is ignored; the source must hold its digit until in_ready.
- in_valid low in COLLECT: no state change, and partially collected digits are retained indefinitely.
- rst asserted in any state, including mid-word or in HOLD with the word not yet taken:
  - Next state is COLLECT with all reset values.
  - The partial or pending word is discarded with no output.
- rst has priority over all handshakes in the same cycle.
- Arithmetic: the subtraction is 4-bit modulo; it is used only for legal codes, so no wrap-around occurs.

Test Plan:
- Reset then four digits, LSD first: 4'h4, 4'h8, 4'hC, 4'h3, with in_last on the last, out_ready=1 -> one cycle later out_valid=1, out_bcd=16'h0951, out_count=4, out_err=0; in_ready=1 again two cycles after the last digit.
- Short word: 4'h7 then 4'h5 with in_last, NDIGITS=4 -> out_bcd=16'h0024, out_count=2, out_err=0.
- Illegal code: digits 4'h3, 4'hF, 4'h6 with in_last -> out_bcd=16'h0300, out_count=3, out_err=1. The next word, digits 4'h4 with in_last, gives out_err=0 and out_bcd=16'h0001.
- Backpressure: complete the word 4'h4 with in_last while out_ready=0 for 5 cycles and in_valid held high with 4'h5 -> out_valid stays 1, out_bcd=16'h0001 stable, in_ready=0 throughout, the held digit is not consumed. After out_ready=1, 4'h5 is accepted as digit 0 of the next word.
- Auto-terminate: five consecutive digits 4'hC with in_last never asserted -> word 1 has out_bcd=16'h9999 and out_count=4; the fifth digit starts word 2 after handoff.
- Mid-operation reset: accept 4'h8 and 4'h9, pulse rst for one cycle, then send 4'h3 with in_last -> out_bcd=16'h0000, out_count=1, out_err=0, with no stale digits present.
